// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: default widths,
// instruction op encodings and the control FSM state type.
package hilo_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 6;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_iter_core.sv
// Single radix-2 step of the iterative multiplier/divider. Purely
// combinational: the caller owns the accumulator register.
//
// Multiply: acc = {partial_hi, multiplier_remaining}. Add the multiplicand
//   to the upper half when the current multiplier bit is set, then shift the
//   whole (DATA_W+1)-bit-carry result right by one.
// Divide (restoring): acc = {remainder, dividend_remaining/quotient}. Shift
//   left by one, try subtracting the divisor from the upper DATA_W+1 bits and
//   keep the difference (quotient bit 1) only when it does not go negative.
// After DATA_W steps the upper half holds product-high / remainder and the
// lower half holds product-low / quotient.
module hilo_iter_core #(
    parameter int DATA_W = 32
) (
    input  logic                  mode_div,
    input  logic [2*DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]     operand,
    output logic [2*DATA_W-1:0]   acc_next
);

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_top;
    logic              div_fits;
    logic [DATA_W-1:0] div_rem;

    // One shift-add or shift-subtract step selected by mode
    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]}
                 + ({1'b0, operand} & {(DATA_W+1){acc[0]}});

        // Upper DATA_W+1 bits of the accumulator after the left shift
        div_top  = acc[2*DATA_W-1:DATA_W-1];
        div_fits = (div_top >= {1'b0, operand});
        // Difference is below the divisor when it fits, so DATA_W bits suffice
        div_rem  = div_top[DATA_W-1:0] - operand;

        if (mode_div) begin
            if (div_fits) begin
                acc_next = {div_rem, acc[DATA_W-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*DATA_W-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with the architectural HI/LO
// registers. Operands are reduced to magnitudes on accept, iterated one bit
// per cycle by hilo_iter_core, and sign-corrected on the final edge.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] Rs,
    input  logic [DATA_W-1:0] Rt,
    input  logic              Flush,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    // Two's-complement negate (also correct for the most negative value)
    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
        return -v;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v);
        return -v;
    endfunction

    // Magnitude of a signed operand; the most negative value maps to its
    // unsigned magnitude 2^(DATA_W-1)
    function automatic logic [DATA_W-1:0] abs_w(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] u;
        u = v;
        return u[DATA_W-1] ? -u : u;
    endfunction

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;

    logic                op_div;
    logic                neg_main;
    logic                neg_rem;
    logic                dbz;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_next;
    logic [DATA_W-1:0]   operand;
    logic [DATA_W-1:0]   rs_raw;

    logic                accept;
    logic                accept_md;
    logic                is_md_op;
    logic                is_div_op;
    logic                is_signed_op;
    logic                rt_zero;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;

    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;

    // Op decode; Op[2]=0 selects mul/div, Op[1] divide, Op[0] unsigned
    assign is_md_op     = ~Op[2];
    assign is_div_op    = Op[1];
    assign is_signed_op = ~Op[0];
    assign rt_zero      = (Rt == '0);

    // Flush suppresses any acceptance, including MTHI/MTLO
    assign accept    = (state == IDLE) && Start && !Flush;
    assign accept_md = accept && is_md_op;

    assign mag_a = is_signed_op ? abs_w(Rs) : Rs;
    assign mag_b = is_signed_op ? abs_w(Rt) : Rt;

    assign Busy = (state != IDLE);

    hilo_iter_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .mode_div (op_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_md) begin
                    state_next = (is_div_op && rt_zero) ? FIN : RUN;
                end
            end
            RUN: begin
                if (Flush) begin
                    state_next = IDLE;
                end else if (cnt == LAST_ITER) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Iteration counter: cleared on accept, advanced once per RUN edge
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt <= '0;
        end else if (accept_md) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Operand latch and accumulator update; data path carries no reset
    always_ff @(posedge Clk) begin
        if (accept_md) begin
            op_div   <= is_div_op;
            acc      <= {{DATA_W{1'b0}}, mag_a};
            operand  <= mag_b;
            rs_raw   <= Rs;
            dbz      <= is_div_op && rt_zero;
            neg_main <= is_signed_op && (Rs[DATA_W-1] ^ Rt[DATA_W-1]);
            neg_rem  <= is_signed_op && is_div_op && Rs[DATA_W-1];
        end else if (state == RUN) begin
            acc <= acc_next;
        end
    end

    // Sign correction and HI/LO selection for the final write
    always_comb begin
        product = neg_main ? neg_2w(acc) : acc;
        quot    = neg_main ? neg_w(acc[DATA_W-1:0]) : acc[DATA_W-1:0];
        rem     = neg_rem ? neg_w(acc[2*DATA_W-1:DATA_W]) : acc[2*DATA_W-1:DATA_W];
        res_hi  = product[2*DATA_W-1:DATA_W];
        res_lo  = product[DATA_W-1:0];
        if (dbz) begin
            res_hi = rs_raw;
            res_lo = '1;
        end else if (op_div) begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    // Architectural HI/LO: MT* writes in IDLE, mul/div writes on the FIN edge
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Hi <= '0;
            Lo <= '0;
        end else if (accept && (Op == OP_MTHI)) begin
            Hi <= Rs;
        end else if (accept && (Op == OP_MTLO)) begin
            Lo <= Rs;
        end else if ((state == FIN) && !Flush) begin
            Hi <= res_hi;
            Lo <= res_lo;
        end
    end

    // Completion pulse in the cycle after a non-flushed FIN edge
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Done <= 1'b0;
        end else begin
            Done <= (state == FIN) && !Flush;
        end
    end

endmodule
